// File: rtl/arc4_encrypt_if.sv
// arc4_encrypt_if: start handshake, key and the two buffer RAM ports of the
// ARC4 encryptor. The slave side is the encryptor; the master side is the
// system around it (start logic plus the plaintext/ciphertext RAMs).
interface arc4_encrypt_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;

  modport master (
    output en, key, pt_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

  modport slave (
    input  en, key, pt_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
endinterface

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor. Reads a length-prefixed plaintext buffer,
// runs the key schedule and keystream over a 256-byte state array and writes
// a length-prefixed ciphertext buffer. Key byte 0 is key[23:16].
// Optional macro ARC4_ZEROIZE_EN: after each message the state array, key
// register and i/j indices are cleared before returning to idle.
module arc4_encrypt (
  input  logic          clk,
  input  logic          rst,
  arc4_encrypt_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_A,
    ST_KSA_B,
    ST_LEN1,
    ST_LEN2,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4
`ifdef ARC4_ZEROIZE_EN
    , ST_ZERO
`endif
  } state_t;

  state_t      state;
  logic [7:0]  s_mem [256];
  logic [23:0] key_q;
  logic [7:0]  i_q;
  logic [7:0]  j_q;
  logic [7:0]  cnt_q;
  logic [7:0]  len_q;
  logic [1:0]  kidx_q;
  logic        rdy_q;
  logic [7:0]  pt_addr_q;
  logic [7:0]  ct_addr_q;
  logic [7:0]  ct_wrdata_q;
  logic        ct_wren_q;

  logic [7:0]  s_i;
  logic [7:0]  s_j;
  logic [7:0]  key_byte;
  logic [7:0]  j_ksa;
  logic [7:0]  j_prga;
  logic [7:0]  pad_idx;
  logic [7:0]  pad;

  assign bus.rdy       = rdy_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.ct_wrdata = ct_wrdata_q;
  assign bus.ct_wren   = ct_wren_q;

  // Index arithmetic for both schedules; the pad is taken from the pre-swap
  // state so the ciphertext byte can be registered in the same cycle as the swap.
  always_comb begin
    s_i = s_mem[i_q];
    s_j = s_mem[j_q];
    case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
    j_ksa   = j_q + s_i + key_byte;
    j_prga  = j_q + s_i;
    pad_idx = s_i + s_j;
    if (pad_idx == i_q) begin
      pad = s_j;
    end else if (pad_idx == j_q) begin
      pad = s_i;
    end else begin
      pad = s_mem[pad_idx];
    end
  end

  // Main sequencer: init, key schedule, length byte, keystream and optional zeroize.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rdy_q       <= 1'b1;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
      key_q       <= 24'd0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      kidx_q      <= 2'd0;
    end else begin
      ct_wren_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            key_q <= bus.key;
            rdy_q <= 1'b0;
            cnt_q <= 8'd0;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          s_mem[cnt_q] <= cnt_q;
          cnt_q        <= cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            i_q    <= 8'd0;
            j_q    <= 8'd0;
            kidx_q <= 2'd0;
            state  <= ST_KSA_A;
          end
        end
        ST_KSA_A: begin
          j_q <= j_ksa;
          if (i_q == 8'hFF) begin
            pt_addr_q <= 8'd0;
          end
          state <= ST_KSA_B;
        end
        ST_KSA_B: begin
          s_mem[i_q] <= s_j;
          s_mem[j_q] <= s_i;
          i_q        <= i_q + 8'd1;
          kidx_q     <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state      <= (i_q == 8'hFF) ? ST_LEN1 : ST_KSA_A;
        end
        ST_LEN1: begin
          len_q       <= bus.pt_rddata;
          ct_addr_q   <= 8'd0;
          ct_wrdata_q <= bus.pt_rddata;
          ct_wren_q   <= 1'b1;
          state       <= ST_LEN2;
        end
        ST_LEN2: begin
          if (len_q == 8'd0) begin
`ifdef ARC4_ZEROIZE_EN
            cnt_q <= 8'd0;
            key_q <= 24'd0;
            i_q   <= 8'd0;
            j_q   <= 8'd0;
            state <= ST_ZERO;
`else
            rdy_q <= 1'b1;
            state <= ST_IDLE;
`endif
          end else begin
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            cnt_q     <= 8'd1;
            pt_addr_q <= 8'd1;
            state     <= ST_P1;
          end
        end
        ST_P1: begin
          i_q   <= i_q + 8'd1;
          state <= ST_P2;
        end
        ST_P2: begin
          j_q   <= j_prga;
          state <= ST_P3;
        end
        ST_P3: begin
          s_mem[i_q]  <= s_j;
          s_mem[j_q]  <= s_i;
          ct_addr_q   <= cnt_q;
          ct_wrdata_q <= bus.pt_rddata ^ pad;
          ct_wren_q   <= 1'b1;
          state       <= ST_P4;
        end
        ST_P4: begin
          if (cnt_q == len_q) begin
`ifdef ARC4_ZEROIZE_EN
            cnt_q <= 8'd0;
            key_q <= 24'd0;
            i_q   <= 8'd0;
            j_q   <= 8'd0;
            state <= ST_ZERO;
`else
            rdy_q <= 1'b1;
            state <= ST_IDLE;
`endif
          end else begin
            cnt_q     <= cnt_q + 8'd1;
            pt_addr_q <= cnt_q + 8'd1;
            state     <= ST_P1;
          end
        end
`ifdef ARC4_ZEROIZE_EN
        ST_ZERO: begin
          s_mem[cnt_q] <= 8'd0;
          cnt_q        <= cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            rdy_q <= 1'b1;
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          rdy_q <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: directed bench for arc4_encrypt with plaintext/ciphertext
// RAM models, a software ARC4 reference and a per-cycle output comparator.
module tb_arc4_encrypt;

`ifdef ARC4_ZEROIZE_EN
  localparam int ZX = 256;
`else
  localparam int ZX = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arc4_encrypt_if bus ();

  arc4_encrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  pt_mem  [256];
  logic [7:0]  ct_mem  [256];
  logic [7:0]  exp_ct  [256];
  logic [7:0]  next_pt [256];
  logic [7:0]  known_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0]  known_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0]  attack_pt [9] = '{8'h08, 8'h41, 8'h74, 8'h74, 8'h61, 8'h63, 8'h6B, 8'h21, 8'h21};

  int cyc = 0;
  int ct_writes = 0;
  int n_checks = 0;
  int n_fail = 0;
  int accept_cycle = 0;
  int exp_len = 0;
  int done_rel = 0;
  int runs_started = 0;
  int runs_finished = 0;
  int runs_aborted = 0;
  int start_writes = 0;
  int rdy_rel = -1;
  int last_wr_rel = -1;
  int cmp_rel;
  int first_accept;
  logic exp_w;
  bit pending = 0;

  // RAM models and cycle counter: synchronous plaintext read, ciphertext write capture.
  always @(posedge clk) begin
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.ct_wren === 1'b1) begin
      ct_mem[bus.ct_addr] <= bus.ct_wrdata;
      ct_writes <= ct_writes + 1;
    end
    cyc <= cyc + 1;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void note_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endfunction

  // Software ARC4 on the plaintext buffer, filling exp_ct.
  function automatic void model_encrypt(input logic [23:0] k);
    int s[256];
    int kb[3];
    int i, j, t, len;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(pt_mem[0]);
    exp_ct[0] = pt_mem[0];
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_ct[n] = pt_mem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  // Per-cycle comparison of write strobe, address, data and rdy against the schedule.
  always @(negedge clk) begin
    if (runs_started != runs_finished + runs_aborted) begin
      cmp_rel = cyc - accept_cycle;
      if (cmp_rel == 1) begin
        rdy_rel = -1;
        last_wr_rel = -1;
      end
      if (cmp_rel >= 1) begin
        exp_w = (cmp_rel == 770) ||
                (exp_len > 0 && cmp_rel >= 774 && cmp_rel <= 770 + 4 * exp_len && (cmp_rel - 770) % 4 == 0);
        check("ct_wren", bus.ct_wren, exp_w);
        if (exp_w) begin
          check("ct_addr", bus.ct_addr, (cmp_rel - 770) / 4);
          check("ct_wrdata", bus.ct_wrdata, exp_ct[(cmp_rel - 770) / 4]);
        end
        check("rdy", bus.rdy, cmp_rel >= done_rel);
        if (bus.ct_wren === 1'b1) last_wr_rel = cmp_rel;
        if (bus.rdy === 1'b1 && rdy_rel < 0) rdy_rel = cmp_rel;
        if (cmp_rel >= done_rel) runs_finished++;
      end
    end
  end

  task automatic checkOutput();
    check("write_count", ct_writes - start_writes, exp_len + 1);
    for (int n = 0; n <= exp_len; n++) begin
      check($sformatf("ct_mem[%0d]", n), ct_mem[n], exp_ct[n]);
    end
    pending = 0;
  endtask

  // Waits for an idle DUT, then starts a run with next_pt as plaintext.
  task automatic applyStimulus(input logic [23:0] k);
    int waited = 0;
    do begin
      @(negedge clk);
      #2;
      waited++;
    end while (!(bus.rdy === 1'b1 && runs_started == runs_finished + runs_aborted) && waited < 3000);
    if (waited >= 3000) note_timeout("start_wait");
    if (pending) checkOutput();
    for (int n = 0; n < 256; n++) pt_mem[n] = next_pt[n];
    model_encrypt(k);
    exp_len = int'(pt_mem[0]);
    done_rel = 771 + 4 * exp_len + ZX;
    bus.key = k;
    bus.en = 1'b1;
    accept_cycle = cyc;
    start_writes = ct_writes;
    pending = 1;
    runs_started++;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while (runs_started != runs_finished + runs_aborted && waited < 3000) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (waited >= 3000) begin
      note_timeout("done_wait");
      runs_aborted++;
    end
  endtask

  task automatic wait_rel(input int target);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((cyc - accept_cycle) != target && guard < 3000);
    if (guard >= 3000) note_timeout("rel_wait");
    #2;
  endtask

  task automatic load_known();
    for (int n = 0; n < 256; n++) next_pt[n] = 8'h00;
    for (int n = 0; n < 10; n++) next_pt[n] = known_pt[n];
  endtask

  initial begin
    $display("[TB] watchdog armed");
    #(600000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.key = 24'd0;
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'h00;
      next_pt[n] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_rdy", bus.rdy, 1);
    check("reset_ct_wren", bus.ct_wren, 0);
    check("reset_pt_addr", bus.pt_addr, 0);
    check("reset_ct_addr", bus.ct_addr, 0);
    check("reset_ct_wrdata", bus.ct_wrdata, 0);
    rst = 1'b0;

    $display("[TB] known vector");
    load_known();
    applyStimulus(24'h4B6579);
    for (int n = 0; n < 10; n++) check($sformatf("model_ct[%0d]", n), exp_ct[n], known_ct[n]);
    waitIdle();
    checkOutput();
    for (int n = 0; n < 10; n++) check($sformatf("known_ct[%0d]", n), ct_mem[n], known_ct[n]);
    check("known_rdy_cycle", rdy_rel, 807 + ZX);
    check("known_last_write", last_wr_rel, 806);

    $display("[TB] zero-length buffer");
    for (int n = 0; n < 256; n++) next_pt[n] = 8'h00;
    applyStimulus(24'h000001);
    waitIdle();
    checkOutput();
    check("len0_ct0", ct_mem[0], 8'h00);
    check("len0_rdy_cycle", rdy_rel, 771 + ZX);

    $display("[TB] en during KSA is ignored");
    load_known();
    applyStimulus(24'h4B6579);
    wait_rel(300);
    bus.key = 24'hABCDEF;
    bus.en = 1'b1;
    @(negedge clk);
    #2;
    bus.en = 1'b0;
    bus.key = 24'd0;
    waitIdle();
    checkOutput();
    for (int n = 0; n < 10; n++) check($sformatf("ignore_ct[%0d]", n), ct_mem[n], known_ct[n]);
    check("ignore_rdy_cycle", rdy_rel, 807 + ZX);

    $display("[TB] reset at P3 of byte 4");
    applyStimulus(24'h4B6579);
    wait_rel(785);
    runs_aborted++;
    pending = 0;
    rst = 1'b1;
    #1;
    check("abort_rdy", bus.rdy, 1);
    check("abort_ct_wren", bus.ct_wren, 0);
    check("abort_write_count", ct_writes - start_writes, 4);
    for (int n = 0; n < 4; n++) check($sformatf("abort_ct[%0d]", n), ct_mem[n], known_ct[n]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_more_writes", ct_writes - start_writes, 4);
    applyStimulus(24'h4B6579);
    waitIdle();
    checkOutput();
    for (int n = 0; n < 10; n++) check($sformatf("rerun_ct[%0d]", n), ct_mem[n], known_ct[n]);

    $display("[TB] back-to-back");
    load_known();
    applyStimulus(24'h4B6579);
    first_accept = accept_cycle;
    for (int n = 0; n < 256; n++) next_pt[n] = 8'h00;
    for (int n = 0; n < 9; n++) next_pt[n] = attack_pt[n];
    applyStimulus(24'h000102);
    check("b2b_accept_gap", accept_cycle - first_accept, 807 + ZX);
    waitIdle();
    checkOutput();

    $display("[TB] full 255-byte buffer");
    next_pt[0] = 8'hFF;
    for (int n = 1; n < 256; n++) next_pt[n] = 8'((n * 7 + 3) % 256);
    applyStimulus(24'hFFFFFF);
    waitIdle();
    checkOutput();
    check("len255_last_write", last_wr_rel, 1790);
    check("len255_rdy_cycle", rdy_rel, 1791 + ZX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
